// File: rtl/mux_scan_seq.sv
// mux_scan_seq: captures a parallel byte and walks an 8:1 mux select across it,
// holding each select value for HOLD cycles, then pulses done.
module mux_scan_seq #(
    parameter int unsigned HOLD = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] din,
    output logic [7:0] data,
    output logic [2:0] sel,
    output logic       ser,
    output logic       bit_valid,
    output logic       last,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned SEL_W   = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(7);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [7:0]       data_nxt;
    logic [SEL_W-1:0] sel_nxt;

    // State, counter, captured word and decoded status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            data      <= '0;
            sel       <= '0;
            bit_valid <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            data      <= data_nxt;
            sel       <= sel_nxt;
            bit_valid <= (state_nxt == SCAN);
            last      <= (state_nxt == SCAN) && (sel_nxt == SEL_LAST);
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
        end
    end

    // Next-state logic: capture from IDLE/DONE, step sel every HOLD cycles in SCAN
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data;
        sel_nxt   = sel;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    data_nxt  = din;
                    sel_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = SCAN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SCAN: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (sel == SEL_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        sel_nxt = sel + SEL_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Local copy of the downstream mux output
    assign ser = data[sel];

endmodule

// File: tb/tb_mux_scan_seq.sv
// tb_mux_scan_seq: two instances (HOLD=1, HOLD=3) checked against an
// elapsed-cycle reference model plus directed scenario checks.
module tb_mux_scan_seq;

    logic       clk;
    logic       reset;
    logic       start_v     [2];
    logic [7:0] din_v       [2];
    logic [7:0] data_w      [2];
    logic [2:0] sel_w       [2];
    logic       ser_w       [2];
    logic       bit_valid_w [2];
    logic       last_w      [2];
    logic       busy_w      [2];
    logic       done_w      [2];

    int checks = 0;
    int errors = 0;

    // reference model: cycles elapsed since capture (0 = idle), word, sel
    int         m_k    [2];
    logic [7:0] m_word [2];
    logic [2:0] m_sel  [2];

    mux_scan_seq #(.HOLD(1)) u_h1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .din(din_v[0]),
        .data(data_w[0]), .sel(sel_w[0]), .ser(ser_w[0]), .bit_valid(bit_valid_w[0]),
        .last(last_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    mux_scan_seq #(.HOLD(3)) u_h3 (
        .clk(clk), .reset(reset), .start(start_v[1]), .din(din_v[1]),
        .data(data_w[1]), .sel(sel_w[1]), .ser(ser_w[1]), .bit_valid(bit_valid_w[1]),
        .last(last_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hold_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s inst%0d observed %0h expected %0h", tag, i, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_k[i] = 0;
            m_word[i] = 8'h00;
            m_sel[i] = 3'd0;
        end
    endtask

    task automatic model_edge();
        int h;
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                h = hold_of(i);
                if (m_k[i] == 0 || m_k[i] == 8 * h + 1) begin
                    if (start_v[i]) begin
                        m_k[i] = 1;
                        m_word[i] = din_v[i];
                    end else begin
                        m_k[i] = 0;
                    end
                end else begin
                    m_k[i] = m_k[i] + 1;
                end
                if (m_k[i] >= 1 && m_k[i] <= 8 * h) m_sel[i] = 3'((m_k[i] - 1) / h);
                else if (m_k[i] == 8 * h + 1) m_sel[i] = 3'd7;
            end
        end
    endtask

    task automatic check_all();
        int  h;
        logic scan;
        for (int i = 0; i < 2; i++) begin
            h = hold_of(i);
            scan = (m_k[i] >= 1 && m_k[i] <= 8 * h);
            chk("data", i, 32'(data_w[i]), 32'(m_word[i]));
            chk("sel", i, 32'(sel_w[i]), 32'(m_sel[i]));
            chk("ser", i, 32'(ser_w[i]), 32'(m_word[i][m_sel[i]]));
            chk("bit_valid", i, 32'(bit_valid_w[i]), 32'(scan));
            chk("last", i, 32'(last_w[i]), 32'(scan && m_sel[i] == 3'd7));
            chk("busy", i, 32'(busy_w[i]), 32'(m_k[i] != 0));
            chk("done", i, 32'(done_w[i]), 32'(m_k[i] == 8 * h + 1));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] got;
        int done0, done1, busy1, ones1, last0, dcnt;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            din_v[i] = 8'h00;
        end
        model_reset();
        #3;
        check_all();
        step();
        step();
        reset = 1'b0;
        step();

        // HOLD=1 with 8'b1011_0010 alongside HOLD=3 with 8'hFF
        din_v[0] = 8'b1011_0010;
        din_v[1] = 8'hFF;
        start_v[0] = 1'b1;
        start_v[1] = 1'b1;
        got = 8'h00;
        done0 = 0; done1 = 0; busy1 = 0; ones1 = 0; last0 = 0;
        for (int j = 1; j <= 27; j++) begin
            step();
            start_v[0] = 1'b0;
            start_v[1] = 1'b0;
            if (bit_valid_w[0]) got[sel_w[0]] = ser_w[0];
            if (done_w[0] && done0 == 0) done0 = j;
            if (done_w[1] && done1 == 0) done1 = j;
            if (busy_w[1]) busy1++;
            if (bit_valid_w[1] && ser_w[1]) ones1++;
            if (last_w[0]) last0++;
        end
        chk("ser_sequence_h1", 0, 32'(got), 32'h0000_00B2);
        chk("done_cycle_h1", 0, 32'(done0), 32'd9);
        chk("last_count_h1", 0, 32'(last0), 32'd1);
        chk("done_cycle_h3", 1, 32'(done1), 32'd25);
        chk("busy_cycles_h3", 1, 32'(busy1), 32'd25);
        chk("ser_ones_h3", 1, 32'(ones1), 32'd24);

        // start pulsed mid-scan with a new din is ignored
        din_v[0] = 8'hC3;
        start_v[0] = 1'b1;
        dcnt = 0;
        for (int j = 1; j <= 14; j++) begin
            step();
            if (done_w[0]) dcnt++;
            if (j == 7) chk("data_stable_midscan", 0, 32'(data_w[0]), 32'h0000_00C3);
            if (j == 5) begin
                start_v[0] = 1'b1;
                din_v[0] = 8'h00;
            end else begin
                start_v[0] = 1'b0;
            end
        end
        chk("single_done_midscan_start", 0, 32'(dcnt), 32'd1);

        // back-to-back scan: start held through DONE
        din_v[0] = 8'h3C;
        start_v[0] = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            step();
            if (j == 9) chk("b2b_first_done", 0, 32'(done_w[0]), 32'd1);
            if (j == 10) begin
                chk("b2b_data", 0, 32'(data_w[0]), 32'h0000_005A);
                chk("b2b_sel", 0, 32'(sel_w[0]), 32'd0);
                chk("b2b_busy", 0, 32'(busy_w[0]), 32'd1);
            end
            if (j == 18) chk("b2b_second_done", 0, 32'(done_w[0]), 32'd1);
            if (j == 8 || j == 9) begin
                start_v[0] = 1'b1;
                din_v[0] = 8'h5A;
            end else begin
                start_v[0] = 1'b0;
            end
        end

        // asynchronous reset between edges at sel=5
        din_v[0] = 8'hA5;
        start_v[0] = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step();
            start_v[0] = 1'b0;
        end
        chk("pre_reset_sel", 0, 32'(sel_w[0]), 32'd5);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("async_rst_sel", 0, 32'(sel_w[0]), 32'd0);
        chk("async_rst_data", 0, 32'(data_w[0]), 32'd0);
        chk("async_rst_busy", 0, 32'(busy_w[0]), 32'd0);
        step();
        reset = 1'b0;
        dcnt = 0;
        for (int j = 1; j <= 6; j++) begin
            step();
            if (done_w[0]) dcnt++;
        end
        chk("no_done_after_abort", 0, 32'(dcnt), 32'd0);
        din_v[0] = 8'h96;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        chk("restart_sel", 0, 32'(sel_w[0]), 32'd0);
        chk("restart_data", 0, 32'(data_w[0]), 32'h0000_0096);
        for (int j = 2; j <= 10; j++) step();

        // randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                start_v[i] = ($urandom_range(0, 3) == 0);
                din_v[i] = 8'($urandom);
            end
            step();
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) start_v[i] = 1'b0;
        for (int n = 0; n < 30; n++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
